// File: rtl/shift_reg_seq_ctrl.sv
// shift_reg_seq_ctrl
// Takes one parallel word over a valid/ready handshake and shifts it out
// serially, MSB first, one bit per clock. It then pulses done for one cycle
// and returns to accepting words. An in-progress shift can be cancelled with
// abort.
//
// Optional feature: when the macro SHIFT_PARITY_EN is defined, an even-parity
// bit (XOR of the accepted word) is sent as one extra serial bit after the
// data bits.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; overrides every other input
//   p_in      parallel word to transmit
//   in_valid  p_in is valid this cycle
//   in_ready  controller can accept a word this cycle (IDLE)
//   abort     cancels an in-progress shift (only sampled in SHIFT)
//   s_out     serial data bit
//   s_valid   s_out carries a data (or parity) bit this cycle
//   busy      transfer in progress (SHIFT or DONE)
//   done      one-cycle pulse on normal completion
//   p_out     copy of the last accepted word, held until the next accept
module shift_reg_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_out
);

`ifdef SHIFT_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  // Sized so the counter never wraps within a transfer.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
`ifdef SHIFT_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
      p_out <= '0;
`ifdef SHIFT_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= p_in;
            p_out <= p_in;
            count <= '0;
`ifdef SHIFT_PARITY_EN
            par   <= ^p_in;
`endif
          end
        end
        SHIFT: begin
          if (abort) begin
            shreg <= '0;
            count <= '0;
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    s_valid    = 1'b0;
    s_out      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        s_valid = 1'b1;
`ifdef SHIFT_PARITY_EN
        // Data bits are exhausted once count reaches WIDTH; send parity.
        s_out   = (count == CW'(WIDTH)) ? par : shreg[WIDTH-1];
`else
        s_out   = shreg[WIDTH-1];
`endif
        if (abort) begin
          state_next = IDLE;
        end else if (count == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Self-checking bench for shift_reg_seq_ctrl (WIDTH=4). Each table row gives
// the outputs expected in one cycle and the inputs driven during that cycle.
module tb_shift_reg_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p_in;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic       s_out;
  logic       s_valid;
  logic       busy;
  logic       done;
  logic [3:0] p_out;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  shift_reg_seq_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .p_in     (p_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .abort    (abort),
    .s_out    (s_out),
    .s_valid  (s_valid),
    .busy     (busy),
    .done     (done),
    .p_out    (p_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] pin;
    logic       ab;
    logic       rdy;
    logic       so;
    logic       sv;
    logic       bsy;
    logic       dn;
    logic [3:0] pout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [3:0] pin,
                     input logic ab, input logic rdy, input logic so,
                     input logic sv, input logic bsy, input logic dn,
                     input logic [3:0] pout);
    vec_t v;
    v = '{r, iv, pin, ab, rdy, so, sv, bsy, dn, pout};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int cyc;
    rst      = 1'b1;
    in_valid = 1'b1;
    p_in     = 4'b1111;
    abort    = 1'b0;

`ifdef SHIFT_PARITY_EN
    //   rst iv pin     ab   rdy so sv bsy dn pout
    add(1, 1, 4'b1111, 0,   1, 0, 0, 0, 0, 4'h0);
    add(0, 1, 4'b1011, 0,   1, 0, 0, 0, 0, 4'h0);  // accept 1011
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'hB);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);  // parity 1
    add(0, 0, 4'b0000, 0,   0, 0, 0, 1, 1, 4'hB);  // done k+6
    add(0, 1, 4'b1011, 0,   1, 0, 0, 0, 0, 4'hB);  // rerun
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'hB);
    add(1, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);  // rst at k+3
    add(0, 0, 4'b0000, 0,   1, 0, 0, 0, 0, 4'h0);
    add(0, 1, 4'b0110, 0,   1, 0, 0, 0, 0, 4'h0);  // accept 0110
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h6);  // parity 0
    add(0, 0, 4'b0000, 0,   0, 0, 0, 1, 1, 4'h6);
    add(0, 0, 4'b0000, 0,   1, 0, 0, 0, 0, 4'h6);
`else
    //   rst iv pin     ab   rdy so sv bsy dn pout
    add(1, 1, 4'b1111, 0,   1, 0, 0, 0, 0, 4'h0);
    add(0, 1, 4'b1001, 0,   1, 0, 0, 0, 0, 4'h0);  // accept 1001
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h9);
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h9);
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h9);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h9);
    add(0, 0, 4'b0000, 0,   0, 0, 0, 1, 1, 4'h9);  // done k+5
    add(0, 1, 4'b1010, 0,   1, 0, 0, 0, 0, 4'h9);  // accept 1010
    add(0, 1, 4'b0111, 0,   0, 1, 1, 1, 0, 4'hA);  // in_valid held
    add(0, 1, 4'b0111, 0,   0, 0, 1, 1, 0, 4'hA);
    add(0, 1, 4'b0111, 0,   0, 1, 1, 1, 0, 4'hA);
    add(0, 1, 4'b0111, 0,   0, 0, 1, 1, 0, 4'hA);
    add(0, 1, 4'b0111, 0,   0, 0, 0, 1, 1, 4'hA);
    add(0, 1, 4'b0111, 0,   1, 0, 0, 0, 0, 4'hA);  // accept 0111
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h7);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h7);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h7);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h7);
    add(0, 0, 4'b0000, 0,   0, 0, 0, 1, 1, 4'h7);
    add(0, 1, 4'b1100, 0,   1, 0, 0, 0, 0, 4'h7);  // accept 1100
    add(0, 1, 4'b0011, 0,   0, 1, 1, 1, 0, 4'hC);  // ignored while busy
    add(0, 1, 4'b0011, 0,   0, 1, 1, 1, 0, 4'hC);
    add(0, 1, 4'b0011, 0,   0, 0, 1, 1, 0, 4'hC);
    add(0, 1, 4'b0011, 0,   0, 0, 1, 1, 0, 4'hC);
    add(0, 0, 4'b0000, 0,   0, 0, 0, 1, 1, 4'hC);
    add(0, 1, 4'b1011, 0,   1, 0, 0, 0, 0, 4'hC);  // accept 1011
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'hB);
    add(0, 0, 4'b0000, 1,   0, 0, 1, 1, 0, 4'hB);  // abort at k+2
    add(0, 0, 4'b0000, 1,   1, 0, 0, 0, 0, 4'hB);  // abort in IDLE
    add(0, 1, 4'b0110, 0,   1, 0, 0, 0, 0, 4'hB);  // accept 0110
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h6);
    add(0, 0, 4'b0000, 1,   0, 0, 1, 1, 0, 4'h6);  // abort on last bit
    add(0, 1, 4'b0101, 0,   1, 0, 0, 0, 0, 4'h6);  // no done; accept 0101
    add(0, 0, 4'b0000, 0,   0, 0, 1, 1, 0, 4'h5);
    add(1, 0, 4'b0000, 0,   0, 1, 1, 1, 0, 4'h5);  // rst mid-transfer
    add(0, 0, 4'b0000, 0,   1, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'b0000, 0,   1, 0, 0, 0, 0, 4'h0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].rdy));
      check("s_out",    i, 32'(s_out),    32'(vecs[i].so));
      check("s_valid",  i, 32'(s_valid),  32'(vecs[i].sv));
      check("busy",     i, 32'(busy),     32'(vecs[i].bsy));
      check("done",     i, 32'(done),     32'(vecs[i].dn));
      check("p_out",    i, 32'(p_out),    32'(vecs[i].pout));
      rst      = vecs[i].rst;
      in_valid = vecs[i].iv;
      p_in     = vecs[i].pin;
      abort    = vecs[i].ab;
    end

    // Accept-to-done latency, then abort during DONE must not disturb it.
    @(negedge clk);
    in_valid = 1'b1;
    p_in     = 4'b1101;
    @(negedge clk);
    in_valid = 1'b0;
    p_in     = 4'b0000;
    cyc      = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 100, 32'(cyc), 32'(NB + 1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("post_done_ready", 101, 32'(in_ready), 32'd1);
    check("post_done_busy",  102, 32'(busy),     32'd0);
    check("post_done_done",  103, 32'(done),     32'd0);
    check("post_done_p_out", 104, 32'(p_out),    32'hD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
